elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
Parametrised, elastic pipeline-stage register for the CPU datapath; successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic data payload plus a control payload between two stages using a valid/ready handshake.
- Two-entry skid storage gives full throughput with a registered in_ready.
- Synchronous flush inserts a bubble whose control bits are zero.

Parameters:
DATA_W, 96, width of data payload (PCs, operands, ALU result, immediates)
CTRL_W, 16, width of control payload (RegWrite, DRen, DWen, MemtoReg, halt, dest reg, ...); always zero in a bubble
FLUSH_CLEARS_DATA, 1, 1: flush also zeroes stored data; 0: data retained, only valid/ctrl cleared

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
flush  in  1  synchronous squash of all stored entries; highest priority
in_valid  in  1  upstream has an entry
in_ready  out  1  stage can accept; registered, equals !S_valid
in_data  in  DATA_W  upstream data payload
in_ctrl  in  CTRL_W  upstream control payload
out_valid  out  1  M_valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  data of entry M
out_ctrl  out  CTRL_W  control of entry M when M_valid, else 0
occupancy  out  2  number of stored entries (0..2)

Behaviour:
Acceptance and storage
- Accept occurs when in_valid && in_ready && !flush. Drain occurs when out_valid && out_ready.
- Storage is main slot M (drives outputs) and skid slot S.
- States: EMPTY (occupancy 0), ONE (M valid), FULL (M and S valid).

State transitions (no flush)
- EMPTY: accept -> ONE, M <= in.
- ONE, accept and drain -> ONE, M <= in.
- ONE, accept only -> FULL, S <= in.
- ONE, drain only -> EMPTY.
- ONE, neither -> hold.
- FULL: in_ready = 0, so there is no accept. Drain -> ONE, M <= S. Otherwise hold.

Ordering, latency and throughput
- Order is strictly FIFO. No entry is duplicated or lost except through flush.
- Latency: an entry accepted at edge N is visible on out_* after edge N; out_valid is high in cycle N+1.
- Throughput is one entry per cycle while out_ready is held high. FULL is reached only after out_ready is low for a cycle with an accept.

Flush
- Flush has priority over accept and drain in the same cycle.
- Next state is EMPTY and both valids clear.
- Ctrl in both slots is zeroed. Data is zeroed only if FLUSH_CLEARS_DATA = 1.
- Any in_valid during a flush cycle is discarded. in_ready may read 1 in that cycle, but nothing is stored.
- A drain handshake in the flush cycle still counts as consumed downstream.

Reset
- nRST low asynchronously forces EMPTY. M/S data and ctrl = 0, out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0.
- in_ready = 1 from the first edge after release, because the stage is empty.
- Reset mid-transfer drops all entries.

Output rules
- out_ctrl is gated by M_valid (a bubble has zero ctrl).
- out_data is not gated.
- out_* are stable while out_valid && !out_ready.

Optional Feature:
Macro PIPE_PERF_EN.
- Defined: adds outputs stall_cnt[31:0], bubble_cnt[31:0], flush_cnt[31:0]. Each counter saturates at 0xFFFFFFFF and is cleared only by nRST (flush does not clear them).
  - stall_cnt increments each cycle with out_valid && !out_ready.
  - bubble_cnt increments each cycle with out_ready && !out_valid.
  - flush_cnt increments each cycle with flush = 1.
- Not defined: ports and logic are absent. Core behaviour is identical.

Decomposition:
Package pipe_pkg holds:
- typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t
- typedef logic [1:0] occ_t
- localparam PERF_W = 32
- saturating-increment function sat_inc

One sub-module, pipe_slot:
- Parametrised on DATA_W and CTRL_W.
- Holds valid, data and ctrl, with load, clear_ctrl and clear_data inputs.
- Instantiated twice (M, S).

Test Plan:
- Reset, then 8 back-to-back in_valid with data 0x10..0x17, out_ready = 1 -> out_data 0x10..0x17 on consecutive cycles, occupancy stays 1, in_ready always 1.
- Send 0xA then 0xB with out_ready = 0 -> occupancy 2, in_ready = 0. Raise out_ready -> 0xA, then 0xB, then out_valid = 0.
- FULL with ctrl 0x00FF and 0x0F0F, assert flush for one cycle with in_valid = 1 and data 0xC -> next cycle out_valid = 0, out_ctrl = 0, occupancy 0, 0xC never appears. With FLUSH_CLEARS_DATA = 1, out_data = 0.
- ONE state, in_valid and out_ready both high with random 50% toggling for 1000 cycles -> scoreboard confirms order preserved, no loss or duplicate, in_ready == (occupancy < 2).
- Assert nRST low asynchronously mid-cycle while FULL -> outputs zero immediately. After release, in_ready = 1 and out_valid = 0.
- With PIPE_PERF_EN: 5 cycles out_valid && !out_ready, 3 idle cycles with out_ready = 1, 2 flush cycles -> stall_cnt = 5, bubble_cnt = 3, flush_cnt = 2.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types, constants and helpers for the elastic pipeline stage register
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t;
  typedef logic [1:0] occ_t;
  localparam int PERF_W = 32;
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && ~&v) ? v + 1'b1 : v;
  endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one storage entry (valid/data/ctrl); ports CLK, nRST, valid_i, load_i, clear_ctrl_i, clear_data_i, data_i, ctrl_i -> valid_o, data_o, ctrl_o; clears win over load
module pipe_slot import pipe_pkg::*; #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              valid_i,
  input  logic              load_i,
  input  logic              clear_ctrl_i,
  input  logic              clear_data_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_i;
      data_q  <= clear_data_i ? '0 : load_i ? data_i : data_q;
      ctrl_q  <= clear_ctrl_i ? '0 : load_i ? ctrl_i : ctrl_q;
    end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;
endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: valid/ready pipeline stage with two-entry skid storage (M drives outputs, S absorbs one extra entry), registered in_ready, synchronous flush to a zero-ctrl bubble; ports CLK, nRST, flush, in_valid/in_ready/in_data/in_ctrl, out_valid/out_ready/out_data/out_ctrl, occupancy; PIPE_PERF_EN adds saturating stall_cnt/bubble_cnt/flush_cnt
module elastic_pipe_reg import pipe_pkg::*; #(
  parameter int DATA_W            = 96,
  parameter int CTRL_W            = 16,
  parameter int FLUSH_CLEARS_DATA = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output occ_t              occupancy
`ifdef PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] bubble_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);
  pipe_state_t       state_q, state_d;
  logic              in_ready_q;
  logic              m_valid, s_valid, acc, drn, m_load, s_load, clr_data;
  logic [DATA_W-1:0] m_data, s_data, m_data_d;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_d;
  assign acc      = in_valid && in_ready_q && !flush;
  assign drn      = m_valid && out_ready;
  assign clr_data = flush && (FLUSH_CLEARS_DATA != 0);
  always_comb begin
    state_d  = flush ? EMPTY :
               state_q == EMPTY ? (acc ? ONE : EMPTY) :
               state_q == ONE ? (acc && !drn ? FULL : !acc && drn ? EMPTY : ONE) :
               (drn ? ONE : FULL);
    m_load   = !flush && (state_q == FULL ? drn : acc && (state_q == EMPTY || drn));
    s_load   = !flush && state_q == ONE && acc && !drn;
    m_data_d = state_q == FULL ? s_data : in_data;
    m_ctrl_d = state_q == FULL ? s_ctrl : in_ctrl;
  end
  // in_ready is precomputed from the next state so it is a flop output yet equals !S_valid
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_d != FULL;
    end
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_m (
    .CLK(CLK), .nRST(nRST), .valid_i(state_d != EMPTY), .load_i(m_load),
    .clear_ctrl_i(flush), .clear_data_i(clr_data), .data_i(m_data_d), .ctrl_i(m_ctrl_d),
    .valid_o(m_valid), .data_o(m_data), .ctrl_o(m_ctrl)
  );
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_s (
    .CLK(CLK), .nRST(nRST), .valid_i(state_d == FULL), .load_i(s_load),
    .clear_ctrl_i(flush), .clear_data_i(clr_data), .data_i(in_data), .ctrl_i(in_ctrl),
    .valid_o(s_valid), .data_o(s_data), .ctrl_o(s_ctrl)
  );
  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign occupancy = {s_valid, m_valid & ~s_valid};
`ifdef PIPE_PERF_EN
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      stall_cnt  <= sat_inc(stall_cnt, m_valid && !out_ready);
      bubble_cnt <= sat_inc(bubble_cnt, out_ready && !m_valid);
      flush_cnt  <= sat_inc(flush_cnt, flush);
    end
`endif
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: directed and random checks of elastic_pipe_reg against a FIFO-queue reference model
module tb_elastic_pipe_reg;
  logic        CLK = 1'b0, nRST = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [95:0] in_data = '0;
  logic [15:0] in_ctrl = '0;
  logic        in_ready, out_valid;
  logic [95:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occupancy;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
`endif
  typedef struct {logic [95:0] d; logic [15:0] c;} ent_t;
  ent_t q[$];
  int n = 0, fails = 0;

  elastic_pipe_reg dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy)
`ifdef PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("out_valid", out_valid, q.size() > 0);
    chk("occupancy", occupancy, q.size());
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_ctrl", out_ctrl, q.size() > 0 ? q[0].c : 16'h0);
    if (q.size() > 0) chk("out_data", out_data, q[0].d);
  endtask

  // one clock: drive, check at negedge, then advance the reference queue at the rising edge
  task automatic cyc(input logic v, input logic [95:0] d, input logic [15:0] c, input logic r, input logic f);
    ent_t e;
    logic acc, drn;
    in_valid = v; in_data = d; in_ctrl = c; out_ready = r; flush = f;
    @(negedge CLK);
    chk_model();
    acc = v && q.size() < 2 && !f;
    drn = q.size() > 0 && r;
    @(posedge CLK);
    if (f) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) begin e.d = d; e.c = c; q.push_back(e); end
    end
    #1;
  endtask

  initial begin
    logic [95:0] rd;
    logic [15:0] rc;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_occupancy", occupancy, 0);
    #4 nRST = 1'b1;
    @(posedge CLK); #1;
    chk("rel_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) cyc(1, 96'h10 + 96'(i), 16'(i + 1), 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 96'hA, 16'h1, 0, 0);
    cyc(1, 96'hB, 16'h2, 0, 0);
    cyc(1, 96'hEE, 16'h3, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    cyc(1, 96'hD1, 16'h00FF, 0, 0);
    cyc(1, 96'hD2, 16'h0F0F, 0, 0);
    cyc(1, 96'hC, 16'h1234, 0, 1);
    chk("flush_out_data", out_data, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    chk("flush_occupancy", occupancy, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    cyc(1, 96'h55, 16'h5, 1, 0);
    for (int i = 0; i < 1000; i++) begin
      rd = {$urandom(), $urandom(), $urandom()};
      rc = 16'($urandom());
      cyc(1'($urandom()), rd, rc, 1'($urandom()), $urandom_range(63) == 0);
    end
    cyc(1, 96'hF1, 16'hAAAA, 0, 0);
    cyc(1, 96'hF2, 16'hBBBB, 0, 0);
    chk("full_occupancy", occupancy, 2);
    #3 nRST = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_occupancy", occupancy, 0);
    q.delete();
    in_valid = 0; out_ready = 0; flush = 0;
    #3 nRST = 1'b1;
    @(posedge CLK); #1;
    chk("arst_rel_in_ready", in_ready, 1);
    chk("arst_rel_out_valid", out_valid, 0);
`ifdef PIPE_PERF_EN
    cyc(1, 96'h77, 16'h7, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 1);
    chk("stall_cnt", stall_cnt, 5);
    chk("bubble_cnt", bubble_cnt, 3);
    chk("flush_cnt", flush_cnt, 2);
`endif
    cyc(1, 96'h99, 16'h9, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
